// File: rtl/i2c_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one I2C master engine.
// One transaction is in flight at a time; a watchdog aborts a stalled transfer.
module i2c_arbiter #(
   parameter int unsigned NREQ    = 4,
   parameter int unsigned TIMEOUT = 255
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NREQ-1:0]      req,
   input  logic [7*NREQ-1:0]    req_addr,
   input  logic [NREQ-1:0]      req_rw,
   input  logic [8*NREQ-1:0]    req_wdata,
   output logic [NREQ-1:0]      gnt,
   output logic [NREQ-1:0]      rsp_valid,
   output logic [7:0]           rsp_rdata,
   output logic                 rsp_nack,
   output logic                 rsp_timeout,
   output logic                 m_start,
   output logic                 m_abort,
   output logic [6:0]           m_address,
   output logic                 m_wen,
   output logic                 m_ren,
   output logic [7:0]           m_data_write,
   input  logic                 m_busy,
   input  logic                 m_done,
   input  logic                 m_nack,
   input  logic [7:0]           m_data_read
);

   localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {StIdle, StIssue, StWait, StResp} state_e;

   state_e           state_q, state_d;
   logic [PW-1:0]    ptr_q, ptr_d;
   logic [PW-1:0]    win_q, win_d;
   logic [7:0]       timer_q, timer_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  rsp_valid_q, rsp_valid_d;
   logic [7:0]       rsp_rdata_q, rsp_rdata_d;
   logic             rsp_nack_q, rsp_nack_d;
   logic             rsp_timeout_q, rsp_timeout_d;
   logic             m_start_q, m_start_d;
   logic             m_abort_q, m_abort_d;
   logic [6:0]       m_address_q, m_address_d;
   logic             m_wen_q, m_wen_d;
   logic             m_ren_q, m_ren_d;
   logic [7:0]       m_data_write_q, m_data_write_d;

   logic             found;
   logic [PW-1:0]    pick;
   int unsigned      idx;

   // First asserted request at or after ptr, wrapping around.
   always_comb begin
      found = 1'b0;
      pick  = '0;
      idx   = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         idx = (32'(ptr_q) + k) % NREQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            pick  = PW'(idx);
         end
      end
   end

   always_comb begin
      state_d        = state_q;
      ptr_d          = ptr_q;
      win_d          = win_q;
      timer_d        = timer_q;
      gnt_d          = gnt_q;
      rsp_valid_d    = '0;
      rsp_rdata_d    = rsp_rdata_q;
      rsp_nack_d     = rsp_nack_q;
      rsp_timeout_d  = rsp_timeout_q;
      m_start_d      = 1'b0;
      m_abort_d      = 1'b0;
      m_address_d    = m_address_q;
      m_wen_d        = m_wen_q;
      m_ren_d        = m_ren_q;
      m_data_write_d = m_data_write_q;
      unique case (state_q)
         StIdle: begin
            if (found) begin
               win_d          = pick;
               gnt_d          = NREQ'(1) << pick;
               m_address_d    = req_addr[7*pick +: 7];
               m_ren_d        = req_rw[pick];
               m_wen_d        = ~req_rw[pick];
               m_data_write_d = req_wdata[8*pick +: 8];
               state_d        = StIssue;
            end
         end
         StIssue: begin
            if (!m_busy) begin
               m_start_d = 1'b1;
               timer_d   = 8'd0;
               state_d   = StWait;
            end
         end
         StWait: begin
            // A completion on the deadline cycle beats the abort.
            if (m_done) begin
               rsp_nack_d    = m_nack;
               rsp_rdata_d   = m_ren_q ? m_data_read : 8'h00;
               rsp_timeout_d = 1'b0;
               rsp_valid_d   = gnt_q;
               state_d       = StResp;
            end else if (timer_q == 8'(TIMEOUT)) begin
               m_abort_d     = 1'b1;
               rsp_nack_d    = 1'b0;
               rsp_rdata_d   = 8'h00;
               rsp_timeout_d = 1'b1;
               rsp_valid_d   = gnt_q;
               state_d       = StResp;
            end else begin
               timer_d = timer_q + 8'd1;
            end
         end
         StResp: begin
            gnt_d          = '0;
            m_address_d    = '0;
            m_wen_d        = 1'b0;
            m_ren_d        = 1'b0;
            m_data_write_d = '0;
            ptr_d          = (32'(win_q) == NREQ - 1) ? '0 : win_q + 1'b1;
            state_d        = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= StIdle;
         ptr_q          <= '0;
         win_q          <= '0;
         timer_q        <= '0;
         gnt_q          <= '0;
         rsp_valid_q    <= '0;
         rsp_rdata_q    <= '0;
         rsp_nack_q     <= 1'b0;
         rsp_timeout_q  <= 1'b0;
         m_start_q      <= 1'b0;
         m_abort_q      <= 1'b0;
         m_address_q    <= '0;
         m_wen_q        <= 1'b0;
         m_ren_q        <= 1'b0;
         m_data_write_q <= '0;
      end else begin
         state_q        <= state_d;
         ptr_q          <= ptr_d;
         win_q          <= win_d;
         timer_q        <= timer_d;
         gnt_q          <= gnt_d;
         rsp_valid_q    <= rsp_valid_d;
         rsp_rdata_q    <= rsp_rdata_d;
         rsp_nack_q     <= rsp_nack_d;
         rsp_timeout_q  <= rsp_timeout_d;
         m_start_q      <= m_start_d;
         m_abort_q      <= m_abort_d;
         m_address_q    <= m_address_d;
         m_wen_q        <= m_wen_d;
         m_ren_q        <= m_ren_d;
         m_data_write_q <= m_data_write_d;
      end
   end

   assign gnt          = gnt_q;
   assign rsp_valid    = rsp_valid_q;
   assign rsp_rdata    = rsp_rdata_q;
   assign rsp_nack     = rsp_nack_q;
   assign rsp_timeout  = rsp_timeout_q;
   assign m_start      = m_start_q;
   assign m_abort      = m_abort_q;
   assign m_address    = m_address_q;
   assign m_wen        = m_wen_q;
   assign m_ren        = m_ren_q;
   assign m_data_write = m_data_write_q;

endmodule
